// File: rtl/bomb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bomb_timer                                                      |
// | Purpose  : Multi-digit BCD countdown timer with arm/pause/defuse/reload,   |
// |            active-low 7-segment outputs and a BOOM LED bank.              |
// | Option   : BOMB_BLINK_EN - LED bank blinks every BLINK_DIV cycles in BOOM  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bomb_timer #(
    parameter int DIGITS    = 2,
    parameter int TICK_DIV  = 50000000,
    parameter int LED_W     = 16,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  load,
    input  logic                  arm,
    input  logic                  pause,
    input  logic                  defuse,
    input  logic [4*DIGITS-1:0]   start_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   hex,
    output logic [LED_W-1:0]      LEDR,
    output logic [1:0]            state,
    output logic                  tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SAFE = 2'b10,
        ST_BOOM = 2'b11
    } state_t;

    localparam int                 PRESC_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    if (DIGITS < 1 || DIGITS > 4 || TICK_DIV < 2 || BLINK_DIV < 1) begin : g_param_err
        $error("bomb_timer: illegal parameter value");
    end

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic [LED_W-1:0]      ledr_q, ledr_d;

    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   dec_val;
    logic                  count_zero;
    logic                  dec_zero;
    logic                  presc_wrap;

    // Per-digit clamp, BCD borrow decrement and segment decode. A digit borrows
    // exactly when every lower digit is zero, so no ripple chain is needed.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] sv_dig;
        logic [3:0] cnt_dig;
        logic       brw;
        logic [6:0] seg;

        assign sv_dig  = start_val[4*i +: 4];
        assign cnt_dig = count_q[4*i +: 4];
        assign load_val[4*i +: 4] = (sv_dig > 4'd9) ? 4'd9 : sv_dig;

        if (i == 0) begin : g_lsd
            assign brw = 1'b1;
        end else begin : g_upper
            assign brw = (count_q[4*i-1:0] == '0);
        end

        assign dec_val[4*i +: 4] = !brw              ? cnt_dig :
                                   (cnt_dig == 4'd0) ? 4'd9    :
                                                       cnt_dig - 4'd1;

        // Segment order {g,f,e,d,c,b,a}, 0 = lit
        always_comb begin
            case (cnt_dig)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end

        assign hex[7*i +: 7] = seg;
    end

    assign count_zero = (count_q == '0);
    assign dec_zero   = (dec_val == '0);
    assign presc_wrap = (presc_q == PRESC_MAX);

    // Priority: load > defuse > tick/decrement > arm
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (load) begin
            state_d = ST_IDLE;
            count_d = load_val;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = count_zero ? ST_BOOM : ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (defuse) begin
                        state_d = ST_SAFE;
                        presc_d = '0;
                    end else if (!pause) begin
                        if (presc_wrap) begin
                            presc_d = '0;
                            tick_d  = 1'b1;
                            count_d = dec_val;
                            if (dec_zero) begin
                                state_d = ST_BOOM;
                            end
                        end else begin
                            presc_d = presc_q + PRESC_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            ledr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            ledr_q  <= ledr_d;
        end
    end

`ifdef BOMB_BLINK_EN
    localparam int                 BLINK_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;

    // Phase starts lit so the first BOOM cycle shows all-1.
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        ledr_d      = '0;
        if (state_q == ST_BOOM) begin
            ledr_d = blink_on_q ? {LED_W{1'b1}} : {LED_W{1'b0}};
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_on_d  = blink_on_q;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`else
    always_comb begin
        ledr_d = (state_q == ST_BOOM) ? {LED_W{1'b1}} : {LED_W{1'b0}};
    end
`endif

    assign count = count_q;
    assign LEDR  = ledr_q;
    assign state = state_q;
    assign tick  = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bomb_timer.sv
`default_nettype none
// Randomised and directed bench for bomb_timer against a decimal-arithmetic
// reference model (DIGITS=2, TICK_DIV=4, BLINK_DIV=3).
module tb_bomb_timer;
    localparam int DIGITS    = 2;
    localparam int TICK_DIV  = 4;
    localparam int LED_W     = 16;
    localparam int BLINK_DIV = 3;

    logic                CLOCK_50 = 1'b0;
    logic                RESET_N  = 1'b0;
    logic                load     = 1'b0;
    logic                arm      = 1'b0;
    logic                pause    = 1'b0;
    logic                defuse   = 1'b0;
    logic [4*DIGITS-1:0] start_val = '0;
    logic [4*DIGITS-1:0] count;
    logic [7*DIGITS-1:0] hex;
    logic [LED_W-1:0]    LEDR;
    logic [1:0]          state;
    logic                tick;

    bomb_timer #(
        .DIGITS    (DIGITS),
        .TICK_DIV  (TICK_DIV),
        .LED_W     (LED_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .load      (load),
        .arm       (arm),
        .pause     (pause),
        .defuse    (defuse),
        .start_val (start_val),
        .count     (count),
        .hex       (hex),
        .LEDR      (LEDR),
        .state     (state),
        .tick      (tick)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    // Reference model: count kept as a plain decimal integer
    int m_state = 0;
    int m_count = 0;
    int m_presc = 0;
    int m_boom_age = 0;
    bit m_tick = 1'b0;
    bit m_led  = 1'b0;

    logic [6:0] seg_tab [10];

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7*DIGITS-1:0] exp_hex(input int v);
        logic [7*DIGITS-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = seg_tab[x % 10];
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*DIGITS-1:0] sv);
        int v = 0;
        int w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d;
            d = int'(sv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_count = 0; m_presc = 0; m_boom_age = 0;
        m_tick = 1'b0; m_led = 1'b0;
    endtask

    // Advance one clock: model computes next values from the current inputs.
    task automatic step();
        int n_state = m_state;
        int n_count = m_count;
        int n_presc = m_presc;
        bit n_tick  = 1'b0;
        bit on;
`ifdef BOMB_BLINK_EN
        on = ((m_boom_age / BLINK_DIV) % 2) == 0;
`else
        on = 1'b1;
`endif
        if (load) begin
            n_state = 0;
            n_count = clamp_val(start_val);
            n_presc = 0;
        end else if (m_state == 0) begin
            if (arm) begin
                n_state = (m_count != 0) ? 1 : 3;
                n_presc = 0;
            end
        end else if (m_state == 1) begin
            if (defuse) begin
                n_state = 2;
                n_presc = 0;
            end else if (!pause) begin
                if (m_presc == TICK_DIV - 1) begin
                    n_presc = 0;
                    n_tick  = 1'b1;
                    n_count = m_count - 1;
                    if (n_count == 0) n_state = 3;
                end else begin
                    n_presc = m_presc + 1;
                end
            end
        end
        @(posedge CLOCK_50);
        #1;
        m_led      = (m_state == 3) && on;
        m_boom_age = (m_state == 3) ? m_boom_age + 1 : 0;
        m_state    = n_state;
        m_count    = n_count;
        m_presc    = n_presc;
        m_tick     = n_tick;
    endtask

    task automatic pulse_load(input logic [4*DIGITS-1:0] v);
        start_val = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        checks++;
        if ({state, count, tick, LEDR, hex} !== {2'b00, 8'h00, 1'b0, 16'h0000, exp_hex(0)}) begin
            errors++;
            $display("FAIL reset: got state=%b count=%h tick=%b LEDR=%h hex=%b, want 00/00/0/0000/%b",
                     state, count, tick, LEDR, hex, exp_hex(0));
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_countdown();
        int cyc = 0;
        pulse_load(8'h12);
        checks++;
        if (state !== 2'b00 || count !== 8'h12) begin
            errors++;
            $display("FAIL load_12: got state=%b count=%h, want 00/12", state, count);
        end
        pulse_arm();
        checks++;
        if (state !== 2'b01 || count !== 8'h12) begin
            errors++;
            $display("FAIL arm_run: got state=%b count=%h, want 01/12", state, count);
        end
        while (m_state == 1 && cyc < 100) begin
            step();
            cyc++;
            checks++;
            if ({state, count, tick, LEDR} !== {2'(m_state), to_bcd(m_count), m_tick, {LED_W{m_led}}}) begin
                errors++;
                $display("FAIL countdown cyc=%0d: got state=%b count=%h tick=%b LEDR=%h, want %0d/%h/%b/%b",
                         cyc, state, count, tick, LEDR, m_state, to_bcd(m_count), m_tick, m_led);
            end
        end
        checks++;
        if (state !== 2'b11 || count !== 8'h00 || cyc !== 12 * TICK_DIV) begin
            errors++;
            $display("FAIL countdown_boom: got state=%b count=%h cycles=%0d, want 11/00/%0d",
                     state, count, cyc, 12 * TICK_DIV);
        end
        step();
        checks++;
        if (LEDR !== {LED_W{1'b1}}) begin
            errors++;
            $display("FAIL boom_led: got LEDR=%h, want ffff", LEDR);
        end
    endtask

    task automatic test_borrow_hex();
        int n = 0;
        pulse_load(8'h10);
        pulse_arm();
        while (!m_tick && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (count !== 8'h09 || tick !== 1'b1 || hex !== {7'b1000000, 7'b0010000}) begin
            errors++;
            $display("FAIL borrow: got count=%h tick=%b hex=%b, want 09/1/%b",
                     count, tick, hex, {7'b1000000, 7'b0010000});
        end
        pulse_load(8'h00);
    endtask

    task automatic test_pause();
        int n = 0;
        pulse_load(8'h05);
        pulse_arm();
        repeat (2) begin step(); n++; end
        pause = 1'b1;
        repeat (10) begin
            step();
            n++;
            checks++;
            if (count !== 8'h05 || tick !== 1'b0 || state !== 2'b01) begin
                errors++;
                $display("FAIL pause_hold: got count=%h tick=%b state=%b, want 05/0/01", count, tick, state);
            end
        end
        pause = 1'b0;
        while (m_state == 1 && n < 100) begin
            step();
            n++;
            checks++;
            if ({state, count, tick} !== {2'(m_state), to_bcd(m_count), m_tick}) begin
                errors++;
                $display("FAIL pause_resume: got state=%b count=%h tick=%b, want %0d/%h/%b",
                         state, count, tick, m_state, to_bcd(m_count), m_tick);
            end
        end
        checks++;
        if (state !== 2'b11 || n !== 5 * TICK_DIV + 10) begin
            errors++;
            $display("FAIL pause_len: got state=%b cycles=%0d, want 11/%0d", state, n, 5 * TICK_DIV + 10);
        end
    endtask

    task automatic test_defuse_final();
        int n = 0;
        pulse_load(8'h02);
        pulse_arm();
        while (!(m_count == 1 && m_presc == TICK_DIV - 1) && n < 20) begin
            step();
            n++;
        end
        defuse = 1'b1;
        step();
        defuse = 1'b0;
        checks++;
        if (state !== 2'b10 || count !== 8'h01 || tick !== 1'b0) begin
            errors++;
            $display("FAIL defuse_final: got state=%b count=%h tick=%b, want 10/01/0", state, count, tick);
        end
        pulse_arm();
        step();
        checks++;
        if (state !== 2'b10 || count !== 8'h01 || LEDR !== '0) begin
            errors++;
            $display("FAIL safe_hold: got state=%b count=%h LEDR=%h, want 10/01/0000", state, count, LEDR);
        end
    endtask

    task automatic test_zero_clamp();
        pulse_load(8'h00);
        pulse_arm();
        checks++;
        if (state !== 2'b11) begin
            errors++;
            $display("FAIL zero_arm: got state=%b, want 11", state);
        end
        pulse_load(8'hFA);
        checks++;
        if (state !== 2'b00 || count !== 8'h99 || hex !== {7'b0010000, 7'b0010000}) begin
            errors++;
            $display("FAIL clamp: got state=%b count=%h hex=%b, want 00/99/%b",
                     state, count, hex, {7'b0010000, 7'b0010000});
        end
    endtask

    task automatic test_blink();
        pulse_load(8'h00);
        pulse_arm();
        repeat (14) begin
            step();
            checks++;
            if (state !== 2'b11 || LEDR !== {LED_W{m_led}}) begin
                errors++;
                $display("FAIL boom_leds: got state=%b LEDR=%h, want 11/%b", state, LEDR, m_led);
            end
        end
        pulse_load(8'h01);
        step();
        checks++;
        if (state !== 2'b00 || LEDR !== '0) begin
            errors++;
            $display("FAIL load_from_boom: got state=%b LEDR=%h, want 00/0000", state, LEDR);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            load      = ($urandom_range(0, 24) == 0);
            start_val = 8'($urandom_range(0, 255));
            arm       = ($urandom_range(0, 5) == 0);
            defuse    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            step();
            checks++;
            if ({state, count, tick, LEDR, hex} !==
                {2'(m_state), to_bcd(m_count), m_tick, {LED_W{m_led}}, exp_hex(m_count)}) begin
                errors++;
                $display("FAIL random c=%0d: got state=%b count=%h tick=%b LEDR=%h hex=%b, want %0d/%h/%b/%b/%b",
                         c, state, count, tick, LEDR, hex, m_state, to_bcd(m_count), m_tick, m_led,
                         exp_hex(m_count));
            end
        end
        load = 1'b0; arm = 1'b0; defuse = 1'b0; pause = 1'b0;
    endtask

    task automatic test_async_reset();
        pulse_load(8'h30);
        pulse_arm();
        repeat (5) step();
        #3;
        RESET_N = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({state, count, tick, LEDR, hex} !== {2'b00, 8'h00, 1'b0, 16'h0000, exp_hex(0)}) begin
            errors++;
            $display("FAIL async_reset: got state=%b count=%h tick=%b LEDR=%h hex=%b, want 00/00/0/0000/%b",
                     state, count, tick, LEDR, hex, exp_hex(0));
        end
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
        test_reset();
        test_countdown();
        test_borrow_hex();
        test_pause();
        test_defuse_final();
        test_zero_clamp();
        test_blink();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
